// File: rtl/mul_pkg.sv
// Shared types and sizing for the HI/LO multiply controller.
package mul_pkg;

    localparam int XLEN      = 32;
    localparam int CNT_W     = 6;
    localparam int LAT_FIXED = XLEN + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mul_iter_dp.sv
// Shift-add multiplier datapath: one partial-product step per enabled cycle.
// Operands are unsigned magnitudes; sign handling lives in the controller.
module mul_iter_dp
    import mul_pkg::*;
#(
    parameter int XLEN = mul_pkg::XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc,
    output logic              mplier_rest_zero
);

    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;

    // Multiplicand shifts left each step, so it always equals a_mag << cnt.
    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        if (load) begin
            mcand_d  = {{XLEN{1'b0}}, a_mag};
            acc_d    = '0;
            mplier_d = b_mag;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end

    assign acc = acc_q;
    // True when the multiplier will be zero after the current step.
    assign mplier_rest_zero = (mplier_q[XLEN-1:1] == '0);

endmodule

// File: rtl/mul_hilo_ctrl.sv
// MULT/MULTU sequencer owning HI/LO, with MFHI/MFLO/MTHI/MTLO and stall generation.
// Optional MUL_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier is zero.
module mul_hilo_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN  = mul_pkg::XLEN,
    parameter int CNT_W = mul_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            rd_hi,
    input  logic            rd_lo,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wr_data,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic              dp_load;
    logic              dp_step;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod;
    logic              mplier_rest_zero;
    logic              last_iter;

    // The most negative value maps onto itself, which is correct when read as unsigned.
    assign a_mag = (is_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
    assign b_mag = (is_signed && b[XLEN-1]) ? (~b + 1'b1) : b;

    assign prod      = neg_q ? (~acc + 1'b1) : acc;
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1)) || (EARLY_EN && mplier_rest_zero);
    assign dp_step   = (state_q == RUN);

    mul_iter_dp #(
        .XLEN (XLEN)
    ) u_dp (
        .clk              (clk),
        .rst_n            (rst_n),
        .load             (dp_load),
        .step             (dp_step),
        .a_mag            (a_mag),
        .b_mag            (b_mag),
        .acc              (acc),
        .mplier_rest_zero (mplier_rest_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dp_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dp_load = 1'b1;
                    neg_d   = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    if (wr_hi) hi_d = wr_data;
                    if (wr_lo) lo_d = wr_data;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = FIX;
            end
            FIX: begin
                {hi_d, lo_d} = prod;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A squash discards whatever the execute stage presented this cycle.
        if (flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dp_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign stall   = busy & (start | rd_hi | rd_lo | wr_hi | wr_lo);
    assign done    = done_q;
    assign rd_data = rd_hi ? hi_q : lo_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Scoreboard bench for mul_hilo_ctrl: expected products queued at issue, checked on done.
module tb_mul_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_signed, rd_hi, rd_lo, wr_hi, wr_lo, flush;
    logic [31:0] a, b, wr_data;
    logic        busy, stall, done;
    logic [31:0] rd_data, hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb_q[$];

    mul_hilo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .rd_hi     (rd_hi),
        .rd_lo     (rd_lo),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wr_data   (wr_data),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .rd_data   (rd_data),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sx, sy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic int model_lat(input logic [31:0] y, input logic s);
`ifdef MUL_EARLY_TERM_EN
        logic [31:0] m;
        int it;
        m  = (s && y[31]) ? -y : y;
        it = 1;
        for (int k = 1; k < 32; k++) if ((m >> k) != 0) it = k + 1;
        return it + 1;
`else
        return 33;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                $display("[TB] done hi=%h lo=%h expect %h", hi, lo, e);
                chk("hilo", {hi, lo}, e);
            end
        end
    end

    // Called at posedge+1; leaves start low at E0+1.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s, input bit push);
        a = x; b = y; is_signed = s; start = 1'b1;
        if (push) sb_q.push_back(model_prod(x, y, s));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        chk(tag, 64'(n), 64'(exp_lat));
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        logic [63:0] e;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 0; is_signed = 0; rd_hi = 0; rd_lo = 0;
        wr_hi = 0; wr_lo = 0; flush = 0; a = 0; b = 0; wr_data = 0;
        idle_cycles(3);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1;
        idle_cycles(1);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done("lat_multu_ff", model_lat(32'hFFFF_FFFF, 1'b0));
        issue(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1);
        wait_done("lat_mult_m3x7", model_lat(32'd7, 1'b1));
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        wait_done("lat_mult_min", model_lat(32'h8000_0000, 1'b1));

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            issue(ra, rb, 1'(i % 2), 1'b1);
            wait_done("lat_rand", model_lat(rb, 1'(i % 2)));
        end

        // MFLO presented one cycle after issue stalls until HI/LO settle.
        e = model_prod(32'h1234_5678, 32'h0000_0FED, 1'b0);
        issue(32'h1234_5678, 32'h0000_0FED, 1'b0, 1'b1);
        rd_lo = 1'b1;
        #1 chk("stall_rd_first", 64'(stall), 64'd1);
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            if (!stall) break;
            n++;
        end
        chk("stall_cycles", 64'(n), 64'(model_lat(32'h0000_0FED, 1'b0) - 1));
        chk("rd_new_lo", 64'(rd_data), 64'(e[31:0]));
        rd_lo = 1'b0;
        idle_cycles(1);

        wr_hi = 1; wr_lo = 1; wr_data = 32'h11;
        @(posedge clk); #1;
        wr_lo = 1; wr_hi = 0; wr_data = 32'h22;
        @(posedge clk); #1;
        wr_lo = 0;
        chk("mt_hilo", {hi, lo}, {32'h11, 32'h22});

        rd_hi = 1; rd_lo = 1;
        #1 chk("rd_both_hi", {31'd0, stall, rd_data}, {32'd0, 32'h11});
        rd_hi = 0;
        #1 chk("rd_lo_idle", 64'(rd_data), 64'h22);
        rd_lo = 0;

        issue(32'hABCD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle_cycles(9);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hilo", {hi, lo}, {32'h11, 32'h22});
        idle_cycles(40);

        start = 1; flush = 1; a = 3; b = 3; is_signed = 0;
        @(posedge clk); #1;
        start = 0; flush = 0;
        chk("flush_over_start", 64'(busy), 64'd0);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle_cycles(4);
        #2 rst_n = 1'b0;
        #1 chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(1);

        wr_hi = 1; wr_data = 32'hDEAD;
        issue(32'd3, 32'd4, 1'b0, 1'b1);
        wr_hi = 0;
        chk("start_beats_wr", 64'(hi), 64'd0);
        wait_done("lat_3x4", model_lat(32'd4, 1'b0));

        issue(32'd5, 32'd1, 1'b0, 1'b1);
        wait_done("lat_5x1", model_lat(32'd1, 1'b0));

        idle_cycles(2);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
